// File: rtl/line_fill_packer.sv
// Refill packer: collects single-word AXI R beats into WR_M_DATA_SIZE-word groups for the cache data array.
// Optional FILL_RESP_CHECK_EN: flags bad rresp / misplaced rlast in err and truncates the fill on an early rlast.
module line_fill_packer #(
    parameter int DATA_SIZE      = 32,
    parameter int BLOCK_SIZE     = 6,
    parameter int WR_M_DATA_SIZE = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [BLOCK_SIZE-1:0]               start_block,
    input  logic                                rvalid,
    output logic                                rready,
    input  logic [DATA_SIZE-1:0]                rdata,
    input  logic                                rlast,
    input  logic [1:0]                          rresp,
    output logic                                fill_we,
    output logic [WR_M_DATA_SIZE*DATA_SIZE-1:0] fill_data,
    output logic [BLOCK_SIZE-1:0]               fill_counter,
    output logic                                busy,
    output logic                                done,
    output logic                                err
);
    localparam int BLOCKS = 1 << BLOCK_SIZE;
    localparam int GROUPS = BLOCKS / WR_M_DATA_SIZE;
    localparam int GW     = WR_M_DATA_SIZE * DATA_SIZE;
    localparam int SLOT_W = (WR_M_DATA_SIZE > 1) ? $clog2(WR_M_DATA_SIZE) : 1;
    localparam int GL_W   = $clog2(GROUPS + 1);
    localparam logic [BLOCK_SIZE-1:0] ALIGN_MASK = ~BLOCK_SIZE'(WR_M_DATA_SIZE - 1);
    localparam logic [BLOCK_SIZE-1:0] STEP       = BLOCK_SIZE'(WR_M_DATA_SIZE);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t              state_reg;
    logic [SLOT_W-1:0]   slot_reg;
    logic [GL_W-1:0]     groups_left_reg;
    logic [GW-1:0]       group_reg;
    logic [GW-1:0]       group_next;
    logic [GW-1:0]       fill_data_reg;
    logic [BLOCK_SIZE-1:0] fill_counter_reg;
    logic                rready_reg;
    logic                fill_we_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                err_reg;
    logic                stop_reg;
    logic                accept;
    logic                last_slot;
    logic                early_last;
    logic                beat_err;

    assign accept    = rvalid & rready_reg;
    assign last_slot = (slot_reg == SLOT_W'(WR_M_DATA_SIZE - 1));

    // Slots below the current one keep collected beats, the current slot takes rdata,
    // and slots above read as zero so a truncated group is zero-filled for free.
    genvar gi;
    generate
        for (gi = 0; gi < WR_M_DATA_SIZE; gi++) begin : g_elem
            assign group_next[gi*DATA_SIZE +: DATA_SIZE] =
                (SLOT_W'(gi) < slot_reg)  ? group_reg[gi*DATA_SIZE +: DATA_SIZE] :
                (SLOT_W'(gi) == slot_reg) ? rdata : '0;
        end
    endgenerate

`ifdef FILL_RESP_CHECK_EN
    logic [BLOCK_SIZE-1:0] beat_reg;
    logic                  final_beat;

    assign final_beat = (beat_reg == BLOCK_SIZE'(BLOCKS - 1));
    assign early_last = rlast & ~final_beat;
    assign beat_err   = (rresp != 2'b00) | (rlast != final_beat);

    always_ff @(posedge clk) begin
        if (rst || (state_reg == IDLE)) begin
            beat_reg <= '0;
        end else if (accept) begin
            beat_reg <= beat_reg + 1'b1;
        end
    end
`else
    logic unused_resp;
    assign unused_resp = ^{rresp, rlast};
    assign early_last  = 1'b0;
    assign beat_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            slot_reg         <= '0;
            groups_left_reg  <= '0;
            group_reg        <= '0;
            fill_data_reg    <= '0;
            fill_counter_reg <= '0;
            rready_reg       <= 1'b0;
            fill_we_reg      <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            err_reg          <= 1'b0;
            stop_reg         <= 1'b0;
        end else begin
            fill_we_reg <= 1'b0;
            done_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg        <= COLLECT;
                        fill_counter_reg <= start_block & ALIGN_MASK;
                        slot_reg         <= '0;
                        groups_left_reg  <= GL_W'(GROUPS);
                        err_reg          <= 1'b0;
                        stop_reg         <= 1'b0;
                        rready_reg       <= 1'b1;
                        busy_reg         <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        group_reg <= group_next;
                        slot_reg  <= slot_reg + 1'b1;
                        if (beat_err) begin
                            err_reg <= 1'b1;
                        end
                        if (last_slot || early_last) begin
                            fill_data_reg <= group_next;
                            fill_we_reg   <= 1'b1;
                            rready_reg    <= 1'b0;
                            stop_reg      <= early_last;
                            state_reg     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    // fill_counter advances only after the pulse so it names element 0 while fill_we is high
                    fill_counter_reg <= fill_counter_reg + STEP;
                    slot_reg         <= '0;
                    groups_left_reg  <= groups_left_reg - 1'b1;
                    if ((groups_left_reg == GL_W'(1)) || stop_reg) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        rready_reg <= 1'b1;
                        state_reg  <= COLLECT;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rready       = rready_reg;
    assign fill_we      = fill_we_reg;
    assign fill_data    = fill_data_reg;
    assign fill_counter = fill_counter_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign err          = err_reg;
endmodule

// File: tb/tb_line_fill_packer.sv
// Randomized bench for line_fill_packer: expected group writes come from a line-level model of the fill.
module tb_line_fill_packer;
    localparam int DW = 32;
    localparam int BS = 6;
    localparam int WM = 4;
    localparam int BLOCKS = 64;
    localparam int GW = WM * DW;

    typedef struct packed {
        logic [BS-1:0] ctr;
        logic [GW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BS-1:0] start_block;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdata;
    logic          rlast;
    logic [1:0]    rresp;
    logic          fill_we;
    logic [GW-1:0] fill_data;
    logic [BS-1:0] fill_counter;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    line_fill_packer #(.DATA_SIZE(DW), .BLOCK_SIZE(BS), .WR_M_DATA_SIZE(WM)) u_dut (
        .clk(clk), .rst(rst), .start(start), .start_block(start_block),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rresp(rresp),
        .fill_we(fill_we), .fill_data(fill_data), .fill_counter(fill_counter),
        .busy(busy), .done(done), .err(err)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] beat_data [BLOCKS];
    logic [1:0]    beat_resp [BLOCKS];
    logic          beat_last [BLOCKS];
    wr_t           exp_q[$];
    wr_t           got_q[$];
    int            exp_beats;
    logic          exp_err;

    int   cyc = 0;
    int   acc, first_rr, last_we_cyc, done_cyc, rr_bad;
    logic hs;

    task automatic check_eq(input string tag, input logic [GW-1:0] got, input logic [GW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line-level model: which beats land in the line, how groups are cut and where they go.
    task automatic build_expected(input logic [BS-1:0] sb);
        logic [BS-1:0] base;
        wr_t w;
        int n;
        base = sb & 6'b111100;
        n = BLOCKS;
        exp_err = 1'b0;
`ifdef FILL_RESP_CHECK_EN
        for (int i = 0; i < BLOCKS - 1; i++) begin
            if (beat_last[i]) begin
                n = i + 1;
                exp_err = 1'b1;
                break;
            end
        end
        for (int i = 0; i < n; i++) if (beat_resp[i] != 2'b00) exp_err = 1'b1;
        if (n == BLOCKS && !beat_last[BLOCKS-1]) exp_err = 1'b1;
`endif
        exp_beats = n;
        exp_q.delete();
        for (int g = 0; g * WM < n; g++) begin
            w.ctr = base + BS'(WM * g);
            for (int j = 0; j < WM; j++)
                w.data[j*DW +: DW] = (g * WM + j < n) ? beat_data[g*WM + j] : '0;
            exp_q.push_back(w);
        end
    endtask

    task automatic prep_beats(input bit by_index);
        for (int i = 0; i < BLOCKS; i++) begin
            beat_data[i] = by_index ? DW'(i) : $urandom;
            beat_resp[i] = 2'b00;
            beat_last[i] = (i == BLOCKS - 1);
        end
    endtask

    // One clock: observe outputs at the falling edge, then advance past the rising edge.
    task automatic step();
        wr_t w;
        @(negedge clk);
        cyc++;
        if (fill_we) begin
            w.ctr = fill_counter;
            w.data = fill_data;
            got_q.push_back(w);
            last_we_cyc = cyc;
            if (rready) rr_bad++;
        end
        if (done && done_cyc < 0) done_cyc = cyc;
        if (rready && first_rr < 0) first_rr = cyc;
        hs = rvalid && rready;
        @(posedge clk);
        if (hs) acc++;
        #1;
    endtask

    task automatic begin_fill(input logic [BS-1:0] sb);
        got_q.delete();
        acc = 0; first_rr = -1; last_we_cyc = -1; done_cyc = -1; rr_bad = 0;
        start_block = sb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drive_beat(input int b, input int mode, inout int hold);
        if (b < BLOCKS) begin
            if (mode == 0) rvalid = 1'b1;
            else if (b == 6 && hold < 10) begin rvalid = 1'b0; hold++; end
            else rvalid = ($urandom_range(0, 2) != 0);
            rdata = beat_data[b];
            rresp = beat_resp[b];
            rlast = beat_last[b];
        end else begin
            rvalid = 1'b0;
        end
    endtask

    // mode 0: gapless rvalid; mode 1: random rvalid with a 10-cycle stall inside group 1
    task automatic run_fill(input logic [BS-1:0] sb, input int mode, input string name);
        int b, hold, n;
        build_expected(sb);
        begin_fill(sb);
        check_eq({name, " busy_after_start"}, busy, 1'b1);
        check_eq({name, " rready_after_start"}, rready, 1'b1);
        b = 0; hold = 0;
        for (int c = 0; c < 3000 && done_cyc < 0; c++) begin
            drive_beat(b, mode, hold);
            step();
            if (hs) b++;
        end
        rvalid = 1'b0;
        check_eq({name, " done_seen"}, done_cyc >= 0, 1'b1);
        check_eq({name, " n_writes"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s ctr[%0d]", name, i), got_q[i].ctr, exp_q[i].ctr);
            check_eq($sformatf("%s data[%0d]", name, i), got_q[i].data, exp_q[i].data);
        end
        check_eq({name, " beats_accepted"}, acc, exp_beats);
        check_eq({name, " done_after_last_we"}, done_cyc - last_we_cyc, 1);
        check_eq({name, " rready_in_write"}, rr_bad, 0);
        check_eq({name, " err"}, err, exp_err);
        check_eq({name, " busy_after_done"}, busy, 1'b0);
        if (mode == 0 && exp_beats == BLOCKS)
            check_eq({name, " gapless_span"}, last_we_cyc - first_rr, 79);
        $display("fill %s: start_block=%0d writes=%0d beats=%0d err=%0b", name, sb, got_q.size(), acc, err);
    endtask

    initial begin
        int b, hold;
        rst = 1'b1; start = 1'b0; start_block = '0;
        rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset rready", rready, 1'b0);
        check_eq("reset fill_we", fill_we, 1'b0);
        check_eq("reset fill_data", fill_data, '0);
        check_eq("reset fill_counter", fill_counter, '0);
        check_eq("reset busy", busy, 1'b0);
        check_eq("reset done", done, 1'b0);
        check_eq("reset err", err, 1'b0);
        rst = 1'b0;
        step();

        prep_beats(1'b1);
        run_fill(6'd0, 0, "aligned");
        check_eq("aligned first_group", exp_q[0].data, {32'd3, 32'd2, 32'd1, 32'd0});

        prep_beats(1'b0);
        run_fill(6'd58, 0, "wrap");

        prep_beats(1'b0);
        run_fill(BS'($urandom_range(0, 63)), 1, "backpressure");

        // Reset after 6 beats: group 0 is already written, group 1 is discarded.
        prep_beats(1'b0);
        build_expected(6'd20);
        begin_fill(6'd20);
        b = 0; hold = 0;
        for (int c = 0; c < 100 && b < 6; c++) begin
            drive_beat(b, 0, hold);
            step();
            if (hs) b++;
        end
        rvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("midrst busy", busy, 1'b0);
        check_eq("midrst rready", rready, 1'b0);
        check_eq("midrst fill_we", fill_we, 1'b0);
        check_eq("midrst fill_counter", fill_counter, '0);
        repeat (4) step();
        check_eq("midrst writes", got_q.size(), 1);
        $display("fill midrst: beats=%0d writes=%0d busy=%0b", b, got_q.size(), busy);
        run_fill(6'd20, 0, "after_rst");

        prep_beats(1'b0);
        beat_resp[5] = 2'b10;
        run_fill(6'd0, 1, "rresp_err");

        prep_beats(1'b0);
        beat_last[9] = 1'b1;
        beat_last[63] = 1'b0;
        run_fill(6'd0, 0, "early_last");

        prep_beats(1'b0);
        beat_last[63] = 1'b0;
        run_fill(6'd12, 0, "no_last");

        for (int k = 0; k < 3; k++) begin
            prep_beats(1'b0);
            run_fill(BS'($urandom_range(0, 63)), 1, $sformatf("rand%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/line_fill_packer.md
# line_fill_packer

Upstream feeder for the cache data array on refills. Accepts single-word AXI4 read-data beats for one cache line, packs them into groups of WR_M_DATA_SIZE words, and presents each group with its block offset for one cycle. The controller converts each write pulse into a multi-word line-fill write into the data array. A fill may start mid-line (critical-word-first); the block offset wraps around within the line.

## Interface
- DATA_SIZE, 32, width of one word / one AXI R beat
- BLOCK_SIZE, 6, log2 of words per line
- WR_M_DATA_SIZE, 4, words per group written to the data array; power of two, ≤ 1<<BLOCK_SIZE
- BLOCKS, 1<<BLOCK_SIZE, words per line (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a line fill; sampled only in IDLE
- start_block  in  BLOCK_SIZE  first word offset of the fill; low log2(WR_M_DATA_SIZE) bits ignored (forced 0)
- rvalid  in  1  AXI R valid
- rready  out  1  AXI R ready
- rdata  in  DATA_SIZE  AXI R data
- rlast  in  1  AXI R last
- rresp  in  2  AXI R response
- fill_we  out  1  one-cycle pulse: fill_data/fill_counter valid for data-array write
- fill_data  out  WR_M_DATA_SIZE×DATA_SIZE  packed group; element i = i-th beat of the group
- fill_counter  out  BLOCK_SIZE  block offset of element 0 of the group
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at fill completion
- err  out  1  sticky error flag; cleared by start or rst

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: rready=0. On start: latch base = start_block with low bits cleared, set fill_counter=base, slot=0, groups_left=BLOCKS/WR_M_DATA_SIZE, clear err → COLLECT.
- COLLECT: rready=1. Each accepted beat (rvalid&rready) is stored in element slot, and slot increments. The beat that fills the last slot → WRITE.
- WRITE: fill_we=1, rready=0, for exactly one cycle. Next: fill_counter += WR_M_DATA_SIZE modulo BLOCKS (wraps 60→0 at defaults), slot=0, groups_left−1. If groups_left was 1 → DONE, else → COLLECT.
- DONE: done=1 for one cycle → IDLE.
- fill_data and fill_counter hold their values outside WRITE; consumers must qualify them with fill_we.
- start while busy is ignored.
- Beat count per fill is exactly BLOCKS. No beat is accepted outside COLLECT.

## Timing
- Reset values: rready=0, fill_we=0, fill_data=0, fill_counter=0, busy=0, done=0, err=0; state IDLE.
- start at cycle T → busy=1 and rready=1 at T+1.
- The last beat of a group accepted at cycle N → fill_we=1 at N+1.
- Throughput: WR_M_DATA_SIZE beats + 1 bubble per group. At defaults a gapless fill takes 16×5 = 80 cycles from the first rready to the last fill_we. done follows the last fill_we by 1 cycle.
- rvalid low stalls COLLECT indefinitely without timeout; the slot is unchanged.
- rst mid-fill: the next cycle is IDLE with all outputs at reset values. The partial group is discarded and no fill_we is issued.

## Configuration
- FILL_RESP_CHECK_EN defined:
  - Any accepted beat with rresp≠2'b00 sets err; its data is still stored.
  - rlast on a beat other than beat BLOCKS−1 sets err. Remaining elements of the current group are zero-filled, that group is written, and the block goes to DONE without accepting further beats.
  - rlast low on beat BLOCKS−1 sets err; the fill completes normally.
- FILL_RESP_CHECK_EN undefined: rresp and rlast are ignored, err is tied to 0, and the fill always consumes BLOCKS beats.

## Test plan
- Aligned fill: start_block=0, 64 gapless beats with rdata=beat index and rlast on beat 63 → 16 fill_we pulses with fill_counter 0,4,…,60; first pulse fill_data={3,2,1,0}; done 1 cycle after the last pulse; err=0.
- Wrap-around: start_block=6'd58 (forced to 56) → fill_counter sequence 56,60,0,4,…,52; 16 pulses; done asserted.
- Backpressure: rvalid toggled randomly and held low 10 cycles mid-group → same packed data as the gapless case; no beat lost or duplicated; rready=0 during every WRITE cycle.
- Reset mid-fill: rst after 6 beats → next cycle busy=0, rready=0, no fill_we; a new start then completes a clean 64-beat fill.
- With FILL_RESP_CHECK_EN, error injection:
  - rresp=2'b10 on beat 5 → err=1; all 16 groups are still written.
  - rlast on beat 9 → err=1; group fill_counter=8 is written as {0,0,beat9,beat8}, then done; beat 10 is not accepted.
- Without FILL_RESP_CHECK_EN, same stimulus → err stays 0; all 64 beats are consumed.
